// File: rtl/stone_drawer.sv
// rtl/stone_drawer.sv - walks the stone RAM and plots one square sprite per visible stone
module stone_drawer #(
    parameter int         SPRITE_SIZE    = 16,
    parameter logic [2:0] COLOUR_STONE   = 3'b111,
    parameter logic [2:0] COLOUR_GOLD    = 3'b110,
    parameter logic [2:0] COLOUR_DIAMOND = 3'b011
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] data,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_DRAW,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [3:0] LAST_OFFSET = 4'(SPRITE_SIZE - 1);
    localparam logic [9:0] X_LIMIT     = 10'd320;
    localparam logic [9:0] Y_LIMIT     = 10'd240;

    state_t      state;
    state_t      state_next;
    logic [3:0]  index;
    logic [3:0]  index_hold;
    logic [3:0]  qty_latched;
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic [8:0]  rec_x;
    logic [7:0]  rec_y;
    logic [1:0]  rec_type;
    logic [9:0]  sum_x;
    logic [9:0]  sum_y;
    logic        last_pixel;
    logic        last_stone;
    logic        on_screen;
    logic        owns_ram;
    logic        unused_fields;

    // Padding bits and the moving flag carry nothing the drawer needs.
    assign unused_fields = ^{data[22:19], data[10:4], data[0]};

    assign sum_x      = {1'b0, rec_x} + {6'b0, dx};
    assign sum_y      = {2'b0, rec_y} + {6'b0, dy};
    assign on_screen  = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
    assign last_pixel = (dx == LAST_OFFSET) && (dy == LAST_OFFSET);
    assign last_stone = ({1'b0, index} + 5'd1) >= {1'b0, qty_latched};
    assign owns_ram   = (state == S_ADDR) || (state == S_WAIT) || (state == S_LATCH)
                     || (state == S_DRAW) || (state == S_NEXT);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (quantity == 4'd0) ? S_FINISH : S_ADDR;
                end
            end
            S_ADDR:  state_next = S_WAIT;
            S_WAIT:  state_next = S_LATCH;
            S_LATCH: state_next = data[1] ? S_DRAW : S_NEXT;
            S_DRAW: begin
                if (last_pixel) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT:   state_next = last_stone ? S_FINISH : S_ADDR;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            index       <= 4'd0;
            index_hold  <= 4'd0;
            qty_latched <= 4'd0;
            dx          <= 4'd0;
            dy          <= 4'd0;
            rec_x       <= 9'd0;
            rec_y       <= 8'd0;
            rec_type    <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        qty_latched <= quantity;
                        index       <= 4'd0;
                    end
                end
                // Two cycles after ADDR the RAM output belongs to this index.
                S_LATCH: begin
                    rec_x    <= data[31:23];
                    rec_y    <= data[18:11];
                    rec_type <= data[3:2];
                    dx       <= 4'd0;
                    dy       <= 4'd0;
                end
                S_DRAW: begin
                    if (dx == LAST_OFFSET) begin
                        dx <= 4'd0;
                        dy <= dy + 4'd1;
                    end else begin
                        dx <= dx + 4'd1;
                    end
                end
                S_NEXT: begin
                    if (!last_stone) begin
                        index <= index + 4'd1;
                    end
                end
                default: ;
            endcase
            if (owns_ram) begin
                index_hold <= index;
            end
        end
    end

    always_comb begin
        draw_stone_flag = owns_ram;
        draw_index      = owns_ram ? index : index_hold;
        busy            = owns_ram;
        done            = (state == S_FINISH);
        x               = 9'd0;
        y               = 8'd0;
        colour          = 3'd0;
        plot            = 1'b0;
        if (state == S_DRAW) begin
            x    = sum_x[8:0];
            y    = sum_y[7:0];
            plot = on_screen;
            case (rec_type)
                2'b00:   colour = COLOUR_STONE;
                2'b01:   colour = COLOUR_GOLD;
                default: colour = COLOUR_DIAMOND;
            endcase
        end
    end

endmodule
